// File: rtl/dld_pkg.sv
// Shared types and defaults for the lsh_seq shifter.
// FSM encoding and width constants.
package dld_pkg;

  localparam int WIDTH_D = 7;
  localparam int SHW_D   = 3;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

endpackage

// File: rtl/lsh1.sv
// Single-bit logical left shift step.
// Zero enters at bit 0, MSB falls off.
module lsh1 #(
  parameter int WIDTH = 7
) (
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  assign q = d << 1;

endmodule

// File: rtl/lsh_seq.sv
// Multi-cycle logical left shifter.
// One bit per cycle, valid/ready on both sides.
module lsh_seq
  import dld_pkg::*;
#(
  parameter int WIDTH = WIDTH_D,
  parameter int SHW   = SHW_D
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [SHW-1:0]   f,
  output logic [WIDTH-1:0] y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  state_t           state;
  state_t           state_n;
  logic [WIDTH-1:0] data;
  logic [WIDTH-1:0] data_n;
  logic [WIDTH-1:0] data_sh;
  logic [SHW-1:0]   count;
  logic [SHW-1:0]   count_n;

  lsh1 #(
    .WIDTH(WIDTH)
  ) u_lsh1 (
    .d(data),
    .q(data_sh)
  );

  // Next-state: accept in IDLE, step in SHIFT, drain in DONE.
  always_comb begin
    state_n = state;
    data_n  = data;
    count_n = count;
    unique case (state)
      IDLE: begin
        if (in_valid) begin
          data_n  = a;
          count_n = f;
          state_n = (f == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        data_n  = data_sh;
        count_n = count - SHW'(1);
        if (count == SHW'(1)) begin
          state_n = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State, data and count registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      data  <= '0;
      count <= '0;
    end else begin
      state <= state_n;
      data  <= data_n;
      count <= count_n;
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign y         = out_valid ? data : '0;

endmodule

// File: tb/tb_lsh_seq.sv
// Scoreboard bench for lsh_seq.
// Stimulus pushes expected y; monitor pops on handshake.
module tb_lsh_seq;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [6:0] a;
  logic [2:0] f;
  logic [6:0] y;
  logic       out_valid;
  logic       out_ready;
  logic       busy;

  int         checks;
  int         errors;
  int         cyc;
  logic [6:0] sbq[$];
  logic [6:0] exp_y;

  lsh_seq #(
    .WIDTH(7),
    .SHW(3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .a(a),
    .f(f),
    .y(y),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: compare every completed output against the scoreboard.
  always @(negedge clk) begin
    if (!reset) begin
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          chk("spurious_out", int'(y), -1);
        end else begin
          exp_y = sbq.pop_front();
          chk("y", int'(y), int'(exp_y));
        end
      end else if (!out_valid) begin
        chk("y_zero_idle", int'(y), 0);
      end
    end
  end

  task automatic send(input logic [6:0] av, input logic [2:0] fv,
                      input logic [6:0] ev, input int lat,
                      input string nm);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({nm, " ready_to"}, int'(in_ready), 1);
    a        = av;
    f        = fv;
    in_valid = 1'b1;
    sbq.push_back(ev);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk({nm, " busy"}, int'(busy), 1);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({nm, " lat"}, n, lat);
    if (out_ready) begin
      @(posedge clk);
      #1;
      chk({nm, " ret_ready"}, int'(in_ready), 1);
      chk({nm, " ret_ov"}, int'(out_valid), 0);
    end
  endtask

  logic [6:0] bva[4];
  logic [6:0] bve[4];
  int         acc[4];

  initial begin
    int n;
    checks    = 0;
    errors    = 0;
    cyc       = 0;
    reset     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    f         = '0;
    #2;
    reset = 1'b1;
    #1;
    chk("rst in_ready", int'(in_ready), 1);
    chk("rst out_valid", int'(out_valid), 0);
    chk("rst busy", int'(busy), 0);
    chk("rst y", int'(y), 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("post_rst ready", int'(in_ready), 1);

    send(7'h55, 3'd2, 7'h54, 2, "t55");
    send(7'h7F, 3'd0, 7'h7F, 0, "t7f_f0");
    send(7'h7F, 3'd7, 7'h00, 7, "t7f_f7");

    out_ready = 1'b0;
    send(7'h01, 3'd3, 7'h08, 3, "hold");
    for (int i = 0; i < 4; i++) begin
      in_valid = (i == 1);
      a        = 7'h7F;
      f        = 3'd0;
      @(posedge clk);
      #1;
      chk("hold y", int'(y), 8);
      chk("hold ov", int'(out_valid), 1);
      chk("hold rdy", int'(in_ready), 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("hold rel rdy", int'(in_ready), 1);
    chk("hold rel ov", int'(out_valid), 0);
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("no_ghost ov", int'(out_valid), 0);
    end

    a        = 7'h11;
    f        = 3'd5;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    chk("mid busy", int'(busy), 1);
    #2;
    reset = 1'b1;
    #1;
    chk("abort y", int'(y), 0);
    chk("abort ov", int'(out_valid), 0);
    chk("abort busy", int'(busy), 0);
    chk("abort rdy", int'(in_ready), 1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("abort rel rdy", int'(in_ready), 1);
    chk("abort sb", sbq.size(), 0);
    send(7'h03, 3'd1, 7'h06, 1, "after_rst");

    bva[0] = 7'h01; bve[0] = 7'h02;
    bva[1] = 7'h40; bve[1] = 7'h00;
    bva[2] = 7'h2A; bve[2] = 7'h54;
    bva[3] = 7'h33; bve[3] = 7'h66;
    in_valid = 1'b1;
    f        = 3'd1;
    for (int i = 0; i < 4; i++) begin
      a = bva[i];
      n = 0;
      while (!in_ready && n < 10) begin
        @(posedge clk);
        #1;
        n++;
      end
      chk("b2b ready_to", int'(in_ready), 1);
      sbq.push_back(bve[i]);
      @(posedge clk);
      #1;
      acc[i] = cyc;
      if (i > 0) chk("b2b gap", acc[i] - acc[i-1], 3);
    end
    in_valid = 1'b0;

    n = 0;
    while (sbq.size() != 0 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("sb drain", sbq.size(), 0);
    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
